// File: rtl/shiftreg_arb_ctrl.sv
// rtl/shiftreg_arb_ctrl.sv - round-robin arbiter that serially loads a word into an external shift register and verifies it
// Two requesters compete for one external shift register; the winner's word is shifted in LSB first and read back.
module shiftreg_arb_ctrl #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  output logic         sr_din,
  output logic         sr_en,
  input  logic [W-1:0] sr_q,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic         done_ok
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  word;
  logic          id;
  logic          last;

  logic any_valid;
  logic grant_id;
  logic accept;

  // Only a genuine tie looks at the last-served pointer.
  assign any_valid = req0_valid | req1_valid;
  assign grant_id  = (req0_valid & req1_valid) ? ~last : req1_valid;
  assign accept    = (state == IDLE) & any_valid & ~rst;

  assign req0_ready = accept & ~grant_id;
  assign req1_ready = accept & grant_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      word  <= '0;
      id    <= 1'b0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            word  <= grant_id ? req1_data : req0_data;
            id    <= grant_id;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == CW'(W - 1)) begin
            state <= CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          last  <= id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low during reset regardless of the state being abandoned.
  assign busy    = (state != IDLE) & ~rst;
  assign sr_en   = (state == SHIFT) & ~rst;
  assign sr_din  = sr_en & word[cnt];
  assign done    = (state == CHECK) & ~rst;
  assign done_id = done & id;
  assign done_ok = done & (sr_q == word);

endmodule

// File: tb/tb_shiftreg_arb_ctrl.sv
// tb/tb_shiftreg_arb_ctrl.sv - self-checking bench for shiftreg_arb_ctrl with a transaction-level model
module tb_shiftreg_arb_ctrl;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0;
  logic [W-1:0] req0_data = '0;
  logic         req0_ready;
  logic         req1_valid = 1'b0;
  logic [W-1:0] req1_data = '0;
  logic         req1_ready;
  logic         sr_din;
  logic         sr_en;
  logic [W-1:0] sr_q;
  logic         busy;
  logic         done;
  logic         done_id;
  logic         done_ok;

  // External shift register, with optional stuck-at-0 bits on its readback.
  logic [W-1:0] sr_reg = '0;
  logic [W-1:0] stuck_mask = '0;
  assign sr_q = sr_reg & ~stuck_mask;

  always @(posedge clk) begin
    if (sr_en) sr_reg <= {sr_din, sr_reg[W-1:1]};
  end

  always #5 clk = ~clk;

  shiftreg_arb_ctrl #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .sr_din     (sr_din),
    .sr_en      (sr_en),
    .sr_q       (sr_q),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .done_ok    (done_ok)
  );

  int   checks = 0;
  int   errors = 0;
  logic last_served = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept cycle, W shift cycles, one check cycle.
  task automatic serve(input logic v0, input logic v1, input logic [W-1:0] d0,
                       input logic [W-1:0] d1, input logic chg);
    logic         win;
    logic [W-1:0] word;
    logic         exp_ok;
    @(posedge clk); #1;
    req0_valid = v0;
    req1_valid = v1;
    req0_data  = d0;
    req1_data  = d1;
    win  = (v0 && v1) ? ~last_served : v1;
    word = win ? d1 : d0;
    @(negedge clk);
    chk("ready0", 32'(req0_ready), 32'(!win));
    chk("ready1", 32'(req1_ready), 32'(win));
    chk("busy_idle", 32'(busy), 32'd0);
    for (int k = 0; k < W; k++) begin
      @(posedge clk); #1;
      if (chg && k == 0) begin
        req0_data = '0;
        req1_data = '0;
      end
      @(negedge clk);
      chk("shift_en", 32'(sr_en), 32'd1);
      chk("shift_din", 32'(sr_din), 32'(word[k]));
      chk("shift_ready", 32'({req0_ready, req1_ready}), 32'd0);
      chk("shift_busy_done", 32'({busy, done}), 32'b10);
    end
    @(posedge clk); #1;
    @(negedge clk);
    exp_ok = ((word & ~stuck_mask) == word);
    chk("done", 32'(done), 32'd1);
    chk("done_id", 32'(done_id), 32'(win));
    chk("done_ok", 32'(done_ok), 32'(exp_ok));
    chk("check_en_din", 32'({sr_en, sr_din}), 32'd0);
    chk("check_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("sr_q", 32'(sr_q), 32'(word & ~stuck_mask));
    last_served = win;
  endtask

  initial begin
    logic [1:0] v;

    // Reset held with both requesters pending: every output stays low.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_outputs",
        32'({req0_ready, req1_ready, sr_en, sr_din, busy, done, done_id, done_ok}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    last_served = 1'b1;

    // Continuous contention alternates starting with req0.
    for (int i = 0; i < 4; i++) serve(1'b1, 1'b1, 5'h0A, 5'h15, 1'b0);

    serve(1'b1, 1'b0, 5'b11001, 5'h00, 1'b0);

    for (int i = 0; i < 3; i++) serve(1'b0, 1'b1, 5'h00, W'($urandom), 1'b0);

    serve(1'b1, 1'b0, 5'b10110, 5'h00, 1'b1);

    stuck_mask = 5'b00100;
    serve(1'b1, 1'b0, 5'b11111, 5'h00, 1'b0);
    serve(1'b0, 1'b1, 5'h00, 5'b01010, 1'b0);
    stuck_mask = '0;

    // Reset in the middle of a shift: no done, pointer back to 1.
    @(posedge clk); #1;
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    req0_data  = W'($urandom);
    @(negedge clk);
    chk("abort_accept", 32'(req0_ready), 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_shift", 32'(sr_en), 32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_outputs",
        32'({req0_ready, req1_ready, sr_en, sr_din, busy, done, done_id, done_ok}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("abort_after", 32'({busy, sr_en, done}), 32'd0);
    last_served = 1'b1;
    serve(1'b0, 1'b1, 5'h00, W'($urandom), 1'b0);
    serve(1'b1, 1'b1, W'($urandom), W'($urandom), 1'b0);

    for (int i = 0; i < 12; i++) begin
      v = 2'($urandom_range(1, 3));
      serve(v[0], v[1], W'($urandom), W'($urandom), 1'($urandom));
    end

    // No request: nothing is granted and the block stays idle.
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_busy", 32'({busy, sr_en, done}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
